ssd1306_digit_writer: RTL and testbench
=======================================

# ssd1306_digit_writer

Renders an 8-digit BCD value (frequency-counter result) onto page 0 of the SSD1306 OLED. Sits downstream of the counter and upstream of `shift_register`, sharing its byte handshake with `ssd1306_init`. It starts only after init reports done, then streams the address-window commands and the glyph column bytes. Digit glyphs come from an internal 5x8 column-major font ROM.

## Interface
Parameters:
- `PAGE`, 0: display page (0-7) written.
- `COL_START`, 0: first column of the 64-column window (0-64).

Ports:
- `clk_in`  in  1  block clock (1 MHz domain shared with `shift_register`).
- `reset`  in  1  asynchronous, active-high; clears all state.
- `init_done`  in  1  high while `ssd1306_init` sequence is complete.
- `digits`  in  32  8 BCD nibbles; [31:28] is leftmost digit.
- `update`  in  1  one-cycle request to redraw with current `digits`.
- `busy`  out  1  high from accepted update until last byte completes.
- `command_start`  out  1  one-cycle byte-send pulse to `shift_register`.
- `command_out`  out  8  byte to send; stable while `command_start` is high and until `command_ready` returns high.
- `command_ready`  in  1  shift register idle.
- `oled_dc`  out  1  0 = command byte, 1 = data byte.
- `oled_csn`  out  1  chip select, active low.

## Operation
- States: IDLE, CMD_SEND, CMD_WAIT, DATA_SEND, DATA_WAIT, DONE.
- IDLE: accept when `update`=1 and `init_done`=1. Latch `digits` into an internal register; set `busy`; go to CMD_SEND. `update` while `init_done`=0 is dropped.
- Command list, `oled_dc`=0: 0x21, COL_START, COL_START+63, 0x22, PAGE, PAGE.
- CMD_SEND: when `command_ready`=1, pulse `command_start` with the current byte, then go to CMD_WAIT.
- CMD_WAIT: wait for `command_ready` to go 0, then back to 1. Advance the index. After byte 5, go to DATA_SEND.
- Data: 64 bytes, `oled_dc`=1. Byte n belongs to digit n[5:3] and column c = n[2:0].
  - c = 0..4: font column c.
  - c = 5..7: 0x00.
- DATA_SEND/DATA_WAIT use the same handshake as the command states. After byte 63, go to DONE.
- DONE: raise `oled_csn` and clear `busy`. If an update is pending, go to CMD_SEND with newly latched digits and `busy` held high; otherwise go to IDLE.
- Font: digits 0-9 use the standard 5x7 glyphs ('0' = 3E 51 49 45 3E, '1' = 00 42 7F 40 00, '8' = 36 49 49 49 36). Nibbles 10-15 render blank (all 0x00).
- `update` while busy sets a single pending flag; further updates coalesce into it. Digits are latched when the redraw restarts, not at request time.
- `init_done` falling in any non-IDLE state: abort to IDLE on the next edge. Clears `oled_csn`=1, `busy`=0, and the pending flag.

## Timing
- Reset values: `busy`=0, `command_start`=0, `command_out`=0x00, `oled_dc`=0, `oled_csn`=1. All state is IDLE, counters 0, pending 0.
- `oled_csn` falls in the cycle `command_start` first pulses. It rises one cycle after the final `command_ready` rising edge.
- `oled_dc` is valid in the pulse cycle and held until the byte completes. It changes only between bytes.
- Exactly one `command_start` pulse per byte. Total per redraw: 70 pulses.
- Accept-to-first-pulse: 1 cycle if `command_ready`=1.
- Simultaneous `update` and DONE: the update becomes the immediate restart; no IDLE cycle occurs.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined: zeros left of the first nonzero digit render blank. The rightmost digit is always drawn, so 0x00000000 shows a single '0'.
- Undefined: all 8 digits are drawn, including leading zeros.
- Byte count (70) is identical in both cases.

## Test plan
- Reset mid-DATA (after byte 20) -> next cycle `oled_csn`=1, `busy`=0, `command_start`=0. The next `update` restarts from 0x21.
- `init_done`=1, `digits`=0x12345678, `update` pulse, model shift register with 8-cycle busy -> observe:
  - 6 command bytes 21 00 3F 22 00 00 with `oled_dc`=0;
  - 64 data bytes starting 00 42 7F 40 00 00 00 00;
  - 70 pulses total, `oled_csn` low throughout.
- `digits`=0x0000008A -> digit 6 bytes are 36 49 49 49 36 00 00 00; digit 7 is all zeros. With `LEADING_ZERO_BLANK_EN`, digits 0-5 are also all zeros.
- Two `update` pulses during a redraw, `digits` changed to 0x99999999 -> exactly one extra redraw of 9s, `busy` stays high between them, 140 pulses total.
- Drop `init_done` after command byte 3 -> abort, `oled_csn`=1, no further pulses. An `update` with `init_done`=0 is ignored.
- Stall `command_ready` low for 100 cycles -> no second pulse, `command_out` unchanged.

Source files
------------

// File: rtl/ssd1306_digit_writer.sv
// ssd1306_digit_writer: draws 8 BCD digits as 5x8 glyphs on one SSD1306 page over the shared byte handshake.
// Define LEADING_ZERO_BLANK_EN to blank zeros left of the first nonzero digit.
module ssd1306_digit_writer #(
  parameter int PAGE = 0,
  parameter int COL_START = 0
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        init_done,
  input  logic [31:0] digits,
  input  logic        update,
  output logic        busy,
  output logic        command_start,
  output logic [7:0]  command_out,
  input  logic        command_ready,
  output logic        oled_dc,
  output logic        oled_csn
);
  typedef enum logic [2:0] {IDLE, CMD_SEND, CMD_WAIT, DATA_SEND, DATA_WAIT, DONE} state_t;
  state_t state, state_n;
  logic [31:0] dig_q;
  logic [5:0] cnt, cnt_n;
  logic low_seen, low_seen_n, pend, pend_n, csn_q, active, load, blank;
  logic [3:0] nib;
  logic [39:0] glyph;
  logic [7:0] cmd_byte, data_byte;

  function automatic logic [39:0] font(input logic [3:0] n);
    case (n)
      4'd0: font = 40'h3E5149453E;
      4'd1: font = 40'h00427F4000;
      4'd2: font = 40'h4261514946;
      4'd3: font = 40'h2141454B31;
      4'd4: font = 40'h1814127F10;
      4'd5: font = 40'h2745454539;
      4'd6: font = 40'h3C4A494930;
      4'd7: font = 40'h0171090503;
      4'd8: font = 40'h3649494936;
      4'd9: font = 40'h064949291E;
      default: font = 40'h0;
    endcase
  endfunction

  assign active = state != IDLE && state != DONE;
  assign load = init_done && ((state == IDLE && update) || (state == DONE && (pend || update)));
  assign busy = active || (state == DONE && load);
  assign command_start = init_done && command_ready && (state == CMD_SEND || state == DATA_SEND);
  assign oled_dc = state == DATA_SEND || state == DATA_WAIT;
  assign oled_csn = !(command_start || (csn_q && active));
  assign cmd_byte = cnt == 6'd0 ? 8'h21 : cnt == 6'd1 ? 8'(COL_START) :
                    cnt == 6'd2 ? 8'(COL_START + 63) : cnt == 6'd3 ? 8'h22 : 8'(PAGE);
  // byte n: digit n[5:3] (leftmost digit in the top nibble), column n[2:0]
  assign nib = dig_q[{~cnt[5:3], 2'b00} +: 4];
  assign glyph = font(nib) << {cnt[2:0], 3'b000};
  assign data_byte = (cnt[2:0] > 3'd4 || blank) ? 8'h00 : glyph[39:32];
  assign command_out = (state == CMD_SEND || state == CMD_WAIT) ? cmd_byte : oled_dc ? data_byte : 8'h00;

`ifdef LEADING_ZERO_BLANK_EN
  logic [7:0] lz;
  for (genvar i = 0; i < 8; i++) begin : g_lz
    assign lz[i] = i < 7 && dig_q[31 -: 4*(i+1)] == '0;
  end
  assign blank = lz[cnt[5:3]];
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    low_seen_n = low_seen;
    pend_n = pend || (active && update);
    if (state != IDLE && !init_done) begin
      state_n = IDLE;
      cnt_n = 6'd0;
      low_seen_n = 1'b0;
      pend_n = 1'b0;
    end else begin
      case (state)
        IDLE: state_n = load ? CMD_SEND : IDLE;
        CMD_SEND, DATA_SEND: begin
          low_seen_n = 1'b0;
          if (command_start) state_n = (state == CMD_SEND) ? CMD_WAIT : DATA_WAIT;
        end
        CMD_WAIT, DATA_WAIT: begin
          if (!command_ready) low_seen_n = 1'b1;
          else if (low_seen) begin
            low_seen_n = 1'b0;
            if (state == CMD_WAIT) begin
              cnt_n = cnt == 6'd5 ? 6'd0 : cnt + 6'd1;
              state_n = cnt == 6'd5 ? DATA_SEND : CMD_SEND;
            end else begin
              cnt_n = cnt + 6'd1;
              state_n = cnt == 6'd63 ? DONE : DATA_SEND;
            end
          end
        end
        default: begin
          pend_n = 1'b0;
          state_n = load ? CMD_SEND : IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 6'd0;
      low_seen <= 1'b0;
      pend <= 1'b0;
      csn_q <= 1'b0;
      dig_q <= 32'h0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      low_seen <= low_seen_n;
      pend <= pend_n;
      csn_q <= active && (csn_q || command_start);
      if (load) dig_q <= digits;
    end
  end
endmodule

// File: tb/tb_ssd1306_digit_writer.sv
// tb_ssd1306_digit_writer: table vectors plus randomized redraws against a byte-list reference model,
// with a modelled shift register holding command_ready low for a configurable number of cycles.
module tb_ssd1306_digit_writer;
  localparam int PG = 0, CS = 0;
  logic clk_in = 0, reset = 1, init_done = 1, update = 0, command_ready = 1;
  logic [31:0] digits = 0;
  logic busy, command_start, oled_dc, oled_csn;
  logic [7:0] command_out;
  int vec = 0, err = 0, cyc = 0, sr_cnt = 0, stall = 8, csn_bad = 0, gap = 0, t0 = 0;
  bit fire = 0, hold_low = 0;
  logic [7:0] got_b[$];
  bit got_dc[$];
  int got_cyc[$];
  logic [39:0] ft [10] = '{40'h3E5149453E, 40'h00427F4000, 40'h4261514946, 40'h2141454B31,
                           40'h1814127F10, 40'h2745454539, 40'h3C4A494930, 40'h0171090503,
                           40'h3649494936, 40'h064949291E};
  typedef struct {logic [31:0] d; int k; logic [7:0] b;} row_t;
  row_t tab[$];
  logic [31:0] last, rd;

  ssd1306_digit_writer #(.PAGE(PG), .COL_START(CS)) dut (
    .clk_in(clk_in), .reset(reset), .init_done(init_done), .digits(digits), .update(update),
    .busy(busy), .command_start(command_start), .command_out(command_out),
    .command_ready(command_ready), .oled_dc(oled_dc), .oled_csn(oled_csn));

  always #5 clk_in = ~clk_in;

  // shift register model: sample at negedge, drive ready just after posedge
  always begin
    @(negedge clk_in);
    cyc++;
    if (command_start) begin
      got_b.push_back(command_out);
      got_dc.push_back(oled_dc);
      got_cyc.push_back(cyc);
      if (oled_csn !== 1'b0) csn_bad++;
      fire = 1;
    end
    if (!command_ready && oled_csn) csn_bad++;
    if (!busy) gap++;
    @(posedge clk_in);
    #1;
    if (fire) begin sr_cnt = stall; fire = 0; end
    else if (sr_cnt > 0) sr_cnt--;
    command_ready = (sr_cnt == 0) && !hold_low;
  end

  function automatic logic [7:0] model(input logic [31:0] d, input int k);
    int n, dg, c;
    logic [31:0] top;
    if (k < 6) begin
      case (k)
        0: return 8'h21;
        1: return 8'(CS);
        2: return 8'(CS + 63);
        3: return 8'h22;
        default: return 8'(PG);
      endcase
    end
    n = k - 6; dg = n / 8; c = n % 8;
    top = d >> (28 - 4*dg);
    if (c > 4 || top[3:0] > 4'd9) return 8'h00;
`ifdef LEADING_ZERO_BLANK_EN
    if (dg < 7 && top == 0) return 8'h00;
`endif
    return ft[top[3:0]][39 - 8*c -: 8];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic clear();
    got_b.delete(); got_dc.delete(); got_cyc.delete(); csn_bad = 0;
  endtask

  task automatic pulse_update();
    @(posedge clk_in); #1; update = 1;
    @(posedge clk_in); #1; update = 0;
  endtask

  task automatic start(input logic [31:0] d);
    @(posedge clk_in); #1; digits = d; update = 1; t0 = cyc;
    @(posedge clk_in); #1; update = 0;
  endtask

  task automatic wait_p(input int n, input bit idle);
    int k = 0;
    while ((got_b.size() < n || (idle && busy)) && k < 5000) begin @(negedge clk_in); k++; end
    chk("wait_bound", k < 5000, 1);
    if (idle) repeat (3) @(negedge clk_in);
  endtask

  task automatic check_range(input logic [31:0] d, input int base);
    chk("byte_count", got_b.size() >= base + 70, 1);
    if (got_b.size() >= base + 70)
      for (int k = 0; k < 70; k++) begin
        chk($sformatf("byte%0d(d=%h)", base + k, d), got_b[base + k], model(d, k));
        chk($sformatf("dc%0d", base + k), got_dc[base + k], k >= 6);
      end
  endtask

  initial begin
    tab.push_back('{32'h12345678, 0, 8'h21});  tab.push_back('{32'h12345678, 1, 8'h00});
    tab.push_back('{32'h12345678, 2, 8'h3F});  tab.push_back('{32'h12345678, 3, 8'h22});
    tab.push_back('{32'h12345678, 4, 8'h00});  tab.push_back('{32'h12345678, 5, 8'h00});
    tab.push_back('{32'h12345678, 6, 8'h00});  tab.push_back('{32'h12345678, 7, 8'h42});
    tab.push_back('{32'h12345678, 8, 8'h7F});  tab.push_back('{32'h12345678, 9, 8'h40});
    tab.push_back('{32'h12345678, 10, 8'h00}); tab.push_back('{32'h12345678, 13, 8'h00});
    tab.push_back('{32'h12345678, 62, 8'h36}); tab.push_back('{32'h12345678, 63, 8'h49});
    tab.push_back('{32'h0000008A, 54, 8'h36}); tab.push_back('{32'h0000008A, 55, 8'h49});
    tab.push_back('{32'h0000008A, 58, 8'h36}); tab.push_back('{32'h0000008A, 59, 8'h00});
    tab.push_back('{32'h0000008A, 62, 8'h00}); tab.push_back('{32'h0000008A, 64, 8'h00});
    tab.push_back('{32'h00000000, 62, 8'h3E}); tab.push_back('{32'h00000000, 66, 8'h3E});
`ifdef LEADING_ZERO_BLANK_EN
    tab.push_back('{32'h0000008A, 7, 8'h00});  tab.push_back('{32'h0000008A, 46, 8'h00});
    tab.push_back('{32'h00000000, 6, 8'h00});
`else
    tab.push_back('{32'h0000008A, 7, 8'h51});  tab.push_back('{32'h0000008A, 46, 8'h3E});
    tab.push_back('{32'h00000000, 6, 8'h3E});
`endif

    repeat (2) @(negedge clk_in);
    chk("rst_busy", busy, 0);
    chk("rst_start", command_start, 0);
    chk("rst_out", command_out, 8'h00);
    chk("rst_dc", oled_dc, 0);
    chk("rst_csn", oled_csn, 1);
    @(posedge clk_in); #1; reset = 0;
    repeat (2) @(negedge clk_in);

    // table-driven vectors
    last = 32'hFFFFFFFF;
    foreach (tab[i]) begin
      if (tab[i].d !== last) begin
        clear();
        start(tab[i].d);
        wait_p(70, 1);
        chk("latency", got_cyc.size() > 0 ? got_cyc[0] - t0 : -1, 2);
        chk("pulses", got_b.size(), 70);
        chk("csn_low", csn_bad, 0);
        chk("csn_idle", oled_csn, 1);
        last = tab[i].d;
      end
      chk($sformatf("tab%0d_byte%0d", i, tab[i].k), got_b.size() > tab[i].k ? got_b[tab[i].k] : 8'hxx, tab[i].b);
    end

    // coalesced updates during a redraw, digits latched at restart
    clear();
    start(32'h13572468);
    wait_p(10, 0);
    gap = 0;
    pulse_update();
    repeat (30) @(negedge clk_in);
    digits = 32'h99999999;
    pulse_update();
    wait_p(140, 0);
    chk("busy_gap", gap, 0);
    wait_p(140, 1);
    chk("pend_pulses", got_b.size(), 140);
    check_range(32'h13572468, 0);
    check_range(32'h99999999, 70);
    chk("pend_csn", csn_bad, 0);

    // init_done drop after command byte 3
    clear();
    start(32'h12345678);
    wait_p(4, 0);
    @(posedge clk_in); #1; init_done = 0;
    repeat (200) @(negedge clk_in);
    chk("abort_pulses", got_b.size(), 4);
    chk("abort_csn", oled_csn, 1);
    chk("abort_busy", busy, 0);
    pulse_update();
    repeat (50) @(negedge clk_in);
    chk("nodone_pulses", got_b.size(), 4);
    chk("nodone_busy", busy, 0);
    @(posedge clk_in); #1; init_done = 1;
    repeat (20) @(negedge clk_in);
    chk("resume_busy", busy, 0);

    // command_ready stuck low
    clear();
    start(32'h55555555);
    wait_p(1, 0);
    hold_low = 1;
    repeat (100) @(negedge clk_in);
    chk("stall_pulses", got_b.size(), 1);
    chk("stall_out", command_out, 8'h21);
    chk("stall_start", command_start, 0);
    hold_low = 0;
    wait_p(70, 1);
    check_range(32'h55555555, 0);

    // async reset mid-data
    clear();
    start(32'h87654321);
    wait_p(27, 0);
    reset = 1;
    @(negedge clk_in);
    chk("mid_rst_csn", oled_csn, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_start", command_start, 0);
    @(posedge clk_in); #1; reset = 0;
    for (int k = 0; k < 50 && !command_ready; k++) @(negedge clk_in);
    clear();
    start(32'h87654321);
    wait_p(70, 1);
    chk("post_rst_pulses", got_b.size(), 70);
    check_range(32'h87654321, 0);

    // randomized redraws with varying shift-register latency
    for (int r = 0; r < 12; r++) begin
      stall = $urandom_range(1, 8);
      rd = $urandom;
      if (r % 3 == 0) rd = rd >> (4 * $urandom_range(1, 7));
      clear();
      start(rd);
      wait_p(70, 1);
      chk($sformatf("rand%0d_pulses", r), got_b.size(), 70);
      chk($sformatf("rand%0d_csn", r), csn_bad, 0);
      check_range(rd, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
